// File: rtl/psum_writeback_arbiter_pkg.sv
// rtl/psum_writeback_arbiter_pkg.sv - shared state codes and default widths for the psum write-back arbiter
package psum_writeback_arbiter_pkg;

    localparam int NUM_PE_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/psum_writeback_arbiter_rr_arbiter.sv
// rtl/psum_writeback_arbiter_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module psum_writeback_arbiter_rr_arbiter #(
    parameter int NUM_PE = 5,
    parameter int IDX_W  = 3
) (
    input  logic [NUM_PE-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_PE-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any_grant
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_PE; k++) begin
            idx = (int'(ptr) + k) % NUM_PE;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/psum_writeback_arbiter.sv
// rtl/psum_writeback_arbiter.sv - round-robin grant of PE results into a one-entry stage feeding the output SRAM
module psum_writeback_arbiter
    import psum_writeback_arbiter_pkg::*;
#(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     cfgStart,
    input  logic [ADDR_W-1:0]        cfgBase,
    input  logic [ADDR_W-1:0]        cfgCount,
    input  logic [NUM_PE-1:0]        peValid,
    input  logic [NUM_PE*DATA_W-1:0] peData,
    output logic [NUM_PE-1:0]        peAck,
    output logic                     memWen,
    output logic [ADDR_W-1:0]        memAddr,
    output logic [DATA_W-1:0]        memWdata,
    input  logic                     memReady,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    state_t              state;
    logic [ADDR_W-1:0]   addr_ptr;
    logic [ADDR_W-1:0]   remaining;
    logic [IDX_W-1:0]    rr_ptr;
    logic                stage_valid;
    logic [NUM_PE-1:0]   grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_grant;
    logic                can_grant;
    logic                take;
    logic [DATA_W-1:0]   win_data;

    psum_writeback_arbiter_rr_arbiter #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req       (peValid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // The stage may refill in the same cycle it drains, which keeps full throughput.
    assign can_grant = (state == ST_RUN) && (!stage_valid || memReady) && (remaining != '0);
    assign take      = can_grant && any_grant;
    assign peAck     = can_grant ? grant : '0;
    assign memWen    = stage_valid;
    assign busy      = (state == ST_RUN) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (grant[i]) win_data = peData[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            addr_ptr    <= '0;
            remaining   <= '0;
            rr_ptr      <= '0;
            stage_valid <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfgStart) begin
                        addr_ptr  <= cfgBase;
                        remaining <= cfgCount;
                        rr_ptr    <= '0;
                        state     <= (cfgCount != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (take) begin
                        stage_valid <= 1'b1;
                        memAddr     <= addr_ptr;
                        memWdata    <= win_data;
                        addr_ptr    <= addr_ptr + 1'b1;
                        remaining   <= remaining - 1'b1;
                        rr_ptr      <= (grant_idx == IDX_W'(NUM_PE - 1)) ? '0 : grant_idx + 1'b1;
                        if (remaining == ADDR_W'(1)) state <= ST_FLUSH;
                    end else if (memReady) begin
                        stage_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (!stage_valid || memReady) begin
                        stage_valid <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_writeback_arbiter.sv
// tb/tb_psum_writeback_arbiter.sv - randomized scenarios checked against a transaction-level write-back model
module tb_psum_writeback_arbiter;

    localparam int NPE = 5;
    localparam int DW  = 16;
    localparam int AW  = 10;

    logic              clk = 1'b0;
    logic              RST = 1'b1;
    logic              cfgStart = 1'b0;
    logic [AW-1:0]     cfgBase = '0;
    logic [AW-1:0]     cfgCount = '0;
    logic [NPE-1:0]    peValid = '0;
    logic [NPE*DW-1:0] peData = 80'h1111_2222_3333_4444_5555;
    logic [NPE-1:0]    peAck;
    logic              memWen;
    logic [AW-1:0]     memAddr;
    logic [DW-1:0]     memWdata;
    logic              memReady = 1'b1;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    psum_writeback_arbiter #(.NUM_PE(NPE), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .RST      (RST),
        .cfgStart (cfgStart),
        .cfgBase  (cfgBase),
        .cfgCount (cfgCount),
        .peValid  (peValid),
        .peData   (peData),
        .peAck    (peAck),
        .memWen   (memWen),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memReady (memReady),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // PE column: hold each request until acked, then present a fresh random result.
    logic [NPE-1:0] req_en = '0;
    logic [NPE-1:0] served = '0;
    logic [NPE-1:0] ack_seen = '0;
    bit dense = 1'b1;
    bit oneshot = 1'b0;
    bit pe_clear = 1'b0;

    always @(negedge clk) begin
        if (pe_clear) begin
            peValid = '0;
            served  = '0;
        end else begin
            for (int i = 0; i < NPE; i++) begin
                if (ack_seen[i]) begin
                    peData[i*DW +: DW] = DW'($urandom);
                    served[i]  = 1'b1;
                    peValid[i] = req_en[i] && !oneshot && (dense || $urandom_range(0, 3) != 0);
                end else if (!peValid[i] && req_en[i] && !(oneshot && served[i]) &&
                             (dense || $urandom_range(0, 1) == 1)) begin
                    peValid[i] = 1'b1;
                end
            end
        end
    end

    // Reference: writes are owed in ack order to base, base+1, ...; acks follow the round-robin rule.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t            wq[$];
    wr_t            w;
    bit             m_active = 1'b0;
    bit             m_done = 1'b0;
    bit             nd;
    int             m_rr = 0;
    int             m_count = 0;
    int             m_acks = 0;
    int             m_writes = 0;
    int             mi;
    logic [AW-1:0]  m_base = '0;
    logic [NPE-1:0] exp_ack;

    always @(negedge clk) begin
        #2;
        if (RST) begin
            wq.delete();
            m_active = 1'b0;
            m_done   = 1'b0;
            m_rr     = 0;
            ack_seen = '0;
            total++;
            if ({peAck, memWen, memAddr, memWdata, busy, done} !== '0) begin
                bad++;
                $display("FAIL reset_values: peAck=%b memWen=%b memAddr=%h memWdata=%h busy=%b done=%b, required all 0",
                         peAck, memWen, memAddr, memWdata, busy, done);
            end
        end else begin
            exp_ack = '0;
            if (m_active && m_acks < m_count && (wq.size() == 0 || memReady)) begin
                for (int k = 0; k < NPE; k++) begin
                    mi = (m_rr + k) % NPE;
                    if (exp_ack == '0 && peValid[mi]) exp_ack[mi] = 1'b1;
                end
            end
            total++;
            if (peAck !== exp_ack) begin
                bad++;
                $display("FAIL model_ack @%0t: got %b expected %b", $time, peAck, exp_ack);
            end
            total++;
            if (memWen !== (wq.size() != 0)) begin
                bad++;
                $display("FAIL model_wen @%0t: got %b expected %b", $time, memWen, wq.size() != 0);
            end
            if (wq.size() != 0) begin
                total++;
                if (memAddr !== wq[0].a || memWdata !== wq[0].d) begin
                    bad++;
                    $display("FAIL model_write @%0t: got %h/%h expected %h/%h",
                             $time, memAddr, memWdata, wq[0].a, wq[0].d);
                end
            end
            total++;
            if (done !== m_done || busy !== m_active) begin
                bad++;
                $display("FAIL model_status @%0t: done=%b busy=%b expected done=%b busy=%b",
                         $time, done, busy, m_done, m_active);
            end
            ack_seen = peAck;
            nd = 1'b0;
            if (wq.size() != 0 && memReady) begin
                void'(wq.pop_front());
                m_writes++;
                if (m_active && m_writes == m_count) begin
                    m_active = 1'b0;
                    nd = 1'b1;
                end
            end
            for (int k = 0; k < NPE; k++) begin
                if (exp_ack[k]) begin
                    w.a = m_base + AW'(m_acks);
                    w.d = peData[k*DW +: DW];
                    wq.push_back(w);
                    m_rr = (k + 1) % NPE;
                    m_acks++;
                end
            end
            if (cfgStart && !m_active && !m_done) begin
                m_base   = cfgBase;
                m_count  = int'(cfgCount);
                m_acks   = 0;
                m_writes = 0;
                m_rr     = 0;
                if (cfgCount == '0) nd = 1'b1;
                else m_active = 1'b1;
            end
            m_done = nd;
        end
    end

    // Observations of one run, inspected by the scenario tasks.
    logic [AW-1:0] q_addr[$];
    int q_ack[$];
    int done_cnt, done_cyc, last_ack_cyc, stall_acks, stall_moves;
    bit timed_out;

    task automatic run_case(input logic [AW-1:0] base, input logic [AW-1:0] count, input int rmode,
                            input int maxc, input logic [NPE-1:0] late_mask, input int late_cyc,
                            input int inj_cyc);
        int bp_left;
        bit bp_used;
        logic [AW-1:0] hold_a;
        logic [DW-1:0] hold_d;
        q_addr.delete();
        q_ack.delete();
        done_cnt = 0; done_cyc = -1; last_ack_cyc = -1;
        stall_acks = 0; stall_moves = 0; timed_out = 1'b1;
        bp_left = 0; bp_used = 1'b0; hold_a = '0; hold_d = '0;
        @(negedge clk);
        cfgBase = base; cfgCount = count; cfgStart = 1'b1; memReady = 1'b1;
        for (int cyc = 1; cyc <= maxc; cyc++) begin
            @(negedge clk);
            cfgStart = 1'b0;
            if (cyc == late_cyc) req_en = req_en | late_mask;
            if (cyc == inj_cyc) begin
                cfgStart = 1'b1; cfgBase = ~base; cfgCount = AW'(1);
            end
            if (rmode == 1) begin
                memReady = 1'($urandom_range(0, 1));
            end else if (rmode == 2) begin
                if (memWen && !bp_used) begin
                    bp_used = 1'b1; bp_left = 4; hold_a = memAddr; hold_d = memWdata;
                end
                memReady = (bp_left == 0);
            end else begin
                memReady = 1'b1;
            end
            #3;
            if (rmode == 2 && bp_left > 0) begin
                if (peAck != '0) stall_acks++;
                if (!memWen || memAddr !== hold_a || memWdata !== hold_d) stall_moves++;
                bp_left--;
            end
            for (int k = 0; k < NPE; k++) begin
                if (peAck[k]) begin
                    q_ack.push_back(k);
                    last_ack_cyc = cyc;
                end
            end
            if (memWen && memReady) q_addr.push_back(memAddr);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        memReady = 1'b1;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL run_timeout: base=%h count=%0d no done within %0d cycles", base, count, maxc);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; dense = 1'b1; oneshot = 1'b0; req_en = '1;
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (memWen !== 1'b0 || memAddr !== '0 || memWdata !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: wen=%b addr=%h data=%h busy=%b done=%b required 0",
                     memWen, memAddr, memWdata, busy, done);
        end
        @(negedge clk);
        RST = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #3;
            total++;
            if (peAck !== '0 || memWen !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_grant: peAck=%b memWen=%b busy=%b required 0", peAck, memWen, busy);
            end
        end
    endtask

    task automatic test_fairness();
        run_case(10'h010, 10'd10, 0, 60, '0, 0, 0);
        total++;
        if (q_ack.size() != 10 || q_addr.size() != 10) begin
            bad++;
            $display("FAIL fair_counts: acks=%0d writes=%0d required 10", q_ack.size(), q_addr.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (q_ack[i] != i % NPE || q_addr[i] !== AW'(16 + i)) begin
                    bad++;
                    $display("FAIL fair_order[%0d]: pe=%0d addr=%h required pe=%0d addr=%h",
                             i, q_ack[i], q_addr[i], i % NPE, 16 + i);
                end
            end
        end
        total++;
        if (done_cnt != 1 || done_cyc - last_ack_cyc != 2) begin
            bad++;
            $display("FAIL fair_done: pulses=%0d lag=%0d required 1 and 2", done_cnt, done_cyc - last_ack_cyc);
        end
    endtask

    task automatic test_backpressure();
        run_case(10'h040, 10'd3, 2, 60, '0, 0, 0);
        total++;
        if (stall_acks != 0 || stall_moves != 0) begin
            bad++;
            $display("FAIL bp_stall: acks_during_stall=%0d unstable=%0d required 0", stall_acks, stall_moves);
        end
        total++;
        if (q_addr.size() != 3 || done_cnt != 1) begin
            bad++;
            $display("FAIL bp_writes: writes=%0d done=%0d required 3 and 1", q_addr.size(), done_cnt);
        end else begin
            total++;
            if (q_addr[0] !== 10'h040 || q_addr[1] !== 10'h041 || q_addr[2] !== 10'h042) begin
                bad++;
                $display("FAIL bp_addr: got %h %h %h required 040 041 042", q_addr[0], q_addr[1], q_addr[2]);
            end
        end
    endtask

    task automatic test_sparse();
        req_en = '0;
        pe_clear = 1'b1;
        repeat (2) @(negedge clk);
        pe_clear = 1'b0;
        oneshot = 1'b1;
        req_en = 5'b01000;
        run_case(10'h100, 10'd2, 0, 60, 5'b00010, 4, 0);
        total++;
        if (q_ack.size() != 2 || q_addr.size() != 2) begin
            bad++;
            $display("FAIL sparse_counts: acks=%0d writes=%0d required 2", q_ack.size(), q_addr.size());
        end else begin
            total++;
            if (q_ack[0] != 3 || q_ack[1] != 1 || q_addr[0] !== 10'h100 || q_addr[1] !== 10'h101) begin
                bad++;
                $display("FAIL sparse_order: pe %0d,%0d addr %h,%h required pe 3,1 addr 100,101",
                         q_ack[0], q_ack[1], q_addr[0], q_addr[1]);
            end
        end
        oneshot = 1'b0;
        req_en = '1;
    endtask

    task automatic test_boundaries();
        run_case(10'h155, 10'd0, 0, 20, '0, 0, 0);
        total++;
        if (done_cyc != 1 || done_cnt != 1 || q_addr.size() != 0 || q_ack.size() != 0) begin
            bad++;
            $display("FAIL zero_count: done_cyc=%0d pulses=%0d writes=%0d acks=%0d required 1 1 0 0",
                     done_cyc, done_cnt, q_addr.size(), q_ack.size());
        end
        run_case(10'h3FE, 10'd4, 0, 60, '0, 0, 0);
        total++;
        if (q_addr.size() != 4) begin
            bad++;
            $display("FAIL wrap_count: writes=%0d required 4", q_addr.size());
        end else begin
            total++;
            if (q_addr[0] !== 10'h3FE || q_addr[1] !== 10'h3FF || q_addr[2] !== 10'h000 || q_addr[3] !== 10'h001) begin
                bad++;
                $display("FAIL wrap_addr: got %h %h %h %h required 3fe 3ff 000 001",
                         q_addr[0], q_addr[1], q_addr[2], q_addr[3]);
            end
        end
    endtask

    task automatic test_ignored_start();
        run_case(10'h020, 10'd8, 0, 60, '0, 0, 3);
        total++;
        if (q_addr.size() != 8 || done_cnt != 1) begin
            bad++;
            $display("FAIL restart_count: writes=%0d done=%0d required 8 and 1", q_addr.size(), done_cnt);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (q_addr[i] !== AW'(32 + i)) begin
                    bad++;
                    $display("FAIL restart_addr[%0d]: got %h required %h", i, q_addr[i], 32 + i);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        int wr;
        wr = 0;
        @(negedge clk);
        cfgBase = 10'h080; cfgCount = 10'd6; cfgStart = 1'b1; memReady = 1'b1;
        for (int cyc = 0; cyc < 30 && wr < 2; cyc++) begin
            @(negedge clk);
            cfgStart = 1'b0;
            #3;
            if (memWen && memReady) wr++;
        end
        total++;
        if (wr != 2) begin
            bad++;
            $display("FAIL midrun_progress: writes=%0d required 2", wr);
        end
        @(negedge clk);
        RST = 1'b1;
        #3;
        total++;
        if (busy !== 1'b0 || memWen !== 1'b0 || memAddr !== '0 || memWdata !== '0 || done !== 1'b0 || peAck !== '0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%b wen=%b addr=%h data=%h done=%b ack=%b required 0",
                     busy, memWen, memAddr, memWdata, done, peAck);
        end
        @(negedge clk);
        RST = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #3;
            total++;
            if (done !== 1'b0 || peAck !== '0 || memWen !== 1'b0) begin
                bad++;
                $display("FAIL midrun_after: done=%b ack=%b wen=%b required 0", done, peAck, memWen);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        dense = 1'b0;
        for (int r = 0; r < 6; r++) begin
            req_en = NPE'($urandom_range(1, (1 << NPE) - 1));
            base   = AW'($urandom);
            count  = AW'($urandom_range(1, 12));
            run_case(base, count, 1, 600, '0, 0, 0);
            total++;
            if (q_addr.size() != int'(count) || done_cnt != 1) begin
                bad++;
                $display("FAIL rand_run%0d: writes=%0d done=%0d required %0d and 1", r, q_addr.size(), done_cnt, count);
            end else begin
                for (int i = 0; i < q_addr.size(); i++) begin
                    total++;
                    if (q_addr[i] !== base + AW'(i)) begin
                        bad++;
                        $display("FAIL rand_addr%0d[%0d]: got %h required %h", r, i, q_addr[i], base + AW'(i));
                    end
                end
            end
        end
        dense = 1'b1;
        req_en = '1;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_boundaries();
        test_ignored_start();
        test_midrun_reset();
        test_random();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
